// File: rtl/uart_recv_data_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_recv_data_if                                               |
// | Purpose  : Receiver-side, APB read-path and status signals of the UART    |
// |            receive data FIFO, with master (driver) and slave (FIFO) views. |
// |            rx_irq exists only when UART_RX_IRQ_EN is defined.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_recv_data_if #(
  parameter int AW = 3
);
  logic          recv_done;
  logic [7:0]    recv_data;
  logic          apb_ren;
  logic [7:0]    apb_rdata;
  logic          ovr_clr;
  logic          rx_valid;
  logic [AW:0]   rx_count;
  logic          rx_full;
  logic          rx_overrun;
`ifdef UART_RX_IRQ_EN
  logic          rx_irq;
`endif

  // Receiver and APB side: drives events, observes data and status
  modport master (
    output recv_done, recv_data, apb_ren, ovr_clr,
    input  apb_rdata, rx_valid, rx_count, rx_full, rx_overrun
`ifdef UART_RX_IRQ_EN
    , input rx_irq
`endif
  );

  // FIFO side
  modport slave (
    input  recv_done, recv_data, apb_ren, ovr_clr,
    output apb_rdata, rx_valid, rx_count, rx_full, rx_overrun
`ifdef UART_RX_IRQ_EN
    , output rx_irq
`endif
  );
endinterface
`default_nettype wire

// File: rtl/uart_recv_data.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_recv_data                                                  |
// | Purpose  : Captures each completed UART byte into a small FIFO; APB read   |
// |            strobes pop the head. Provides valid/count/full/overrun status. |
// |            Optional feature macro: UART_RX_IRQ_EN (registered rx_irq).     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_recv_data #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int IRQ_LEVEL = 1
) (
  input  wire               sys_clk,
  input  wire               sys_rst,
  uart_recv_data_if.slave   bus
);

  localparam logic [AW:0]   FULL_LVL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  // Parameter sanity: DEPTH must equal 2**AW and IRQ_LEVEL must be 1..DEPTH
  if (((1 << AW) != DEPTH) || (IRQ_LEVEL < 1) || (IRQ_LEVEL > DEPTH)) begin : g_param_check
    $error("uart_recv_data: inconsistent DEPTH/AW/IRQ_LEVEL");
  end

  logic              recv_d0, recv_d1;
  logic              ren_d0, ren_d1;
  logic [7:0]        recv_data_d0;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nxt;
  logic              overrun, overrun_nxt;
  logic              recv_evt, rd_evt;
  logic              empty, full;
  logic              pop_ok, push_ok, drop;

  // Edge registers idle high so a level held across reset release is not an event
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      recv_d0      <= 1'b1;
      recv_d1      <= 1'b1;
      ren_d0       <= 1'b1;
      ren_d1       <= 1'b1;
      recv_data_d0 <= 8'h00;
    end else begin
      recv_d0      <= bus.recv_done;
      recv_d1      <= recv_d0;
      ren_d0       <= bus.apb_ren;
      ren_d1       <= ren_d0;
      recv_data_d0 <= bus.recv_data;
    end
  end

  assign recv_evt = recv_d0 & ~recv_d1;
  assign rd_evt   = ren_d0 & ~ren_d1;
  assign empty    = (count == '0);
  assign full     = (count == FULL_LVL);
  // A pop at full frees the slot the simultaneous push then takes
  assign pop_ok   = rd_evt & ~empty;
  assign push_ok  = recv_evt & (~full | pop_ok);
  assign drop     = recv_evt & full & ~pop_ok;

  // Next occupancy and overrun (a drop beats a same-cycle clear)
  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CNT_ONE;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - CNT_ONE;
    end
    overrun_nxt = drop | (overrun & ~bus.ovr_clr);
  end

  // Pointer, count and flag state
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count   <= count_nxt;
      overrun <= overrun_nxt;
    end
  end

  // FIFO storage, deliberately not reset
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= recv_data_d0;
    end
  end

  assign bus.apb_rdata  = empty ? 8'h00 : mem[rd_ptr];
  assign bus.rx_valid   = ~empty;
  assign bus.rx_count   = count;
  assign bus.rx_full    = full;
  assign bus.rx_overrun = overrun;

`ifdef UART_RX_IRQ_EN
  localparam logic [AW:0] IRQ_LVL = IRQ_LEVEL[AW:0];
  logic irq;

  // Interrupt registered from next-state level and overrun
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (count_nxt >= IRQ_LVL) | overrun_nxt;
    end
  end

  assign bus.rx_irq = irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_recv_data.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_recv_data                                               |
// | Purpose  : Directed scoreboard bench for uart_recv_data. Expected bytes are |
// |            queued as pushes are issued; a monitor pops and compares at    |
// |            every APB read strobe that finds the FIFO non-empty.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_recv_data;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   errors  = 0;
  int   checks  = 0;
  logic [7:0] exp_q[$];
  logic ren_prev = 1'b0;

  uart_recv_data_if #(.AW(3)) bus ();

  uart_recv_data #(.DEPTH(8), .AW(3), .IRQ_LEVEL(2)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: a rising read strobe with data present consumes the queue head
  always @(negedge sys_clk) begin
    if (bus.apb_ren && !ren_prev && bus.rx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %02h, required queue empty", bus.apb_rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.apb_rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %02h, required %02h", bus.apb_rdata, e);
        end
      end
    end
    ren_prev = bus.apb_ren;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    bus.recv_done = 1'b1;
    bus.recv_data = b;
    tick();
    bus.recv_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    bus.apb_ren = 1'b1;
    tick();
    bus.apb_ren = 1'b0;
    tick();
    tick();
  endtask

  task automatic both(input logic [7:0] b);
    exp_q.push_back(b);
    bus.recv_done = 1'b1;
    bus.recv_data = b;
    bus.apb_ren   = 1'b1;
    tick();
    bus.recv_done = 1'b0;
    bus.apb_ren   = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.recv_done = 1'b0;
    bus.recv_data = 8'h00;
    bus.apb_ren   = 1'b0;
    bus.ovr_clr   = 1'b0;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();

    // Reset state
    check("rst_count",   32'(bus.rx_count), 0);
    check("rst_valid",   32'(bus.rx_valid), 0);
    check("rst_full",    32'(bus.rx_full), 0);
    check("rst_overrun", 32'(bus.rx_overrun), 0);
    check("rst_rdata",   32'(bus.apb_rdata), 32'h00);

    // Single byte
    push(8'h41, 1'b1);
    check("single_valid", 32'(bus.rx_valid), 1);
    check("single_count", 32'(bus.rx_count), 1);
    check("single_rdata", 32'(bus.apb_rdata), 32'h41);
    pop();
    check("single_empty", 32'(bus.rx_valid), 0);
    check("single_rdata0", 32'(bus.apb_rdata), 32'h00);

    // Held levels produce one event each
    exp_q.push_back(8'h55);
    bus.recv_done = 1'b1;
    bus.recv_data = 8'h55;
    repeat (10) tick();
    bus.recv_done = 1'b0;
    tick();
    tick();
    check("held_push_count", 32'(bus.rx_count), 1);
    bus.apb_ren = 1'b1;
    repeat (10) tick();
    bus.apb_ren = 1'b0;
    tick();
    tick();
    check("held_pop_count", 32'(bus.rx_count), 0);

    // Fill, overrun, clear
    for (int i = 0; i < 9; i++) push(8'(i), i < 8);
    check("fill_full",    32'(bus.rx_full), 1);
    check("fill_count",   32'(bus.rx_count), 8);
    check("fill_overrun", 32'(bus.rx_overrun), 1);
    for (int i = 0; i < 8; i++) pop();
    check("drain_valid",  32'(bus.rx_valid), 0);
    check("drain_overrun_sticky", 32'(bus.rx_overrun), 1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    check("ovr_clr", 32'(bus.rx_overrun), 0);

    // Simultaneous push and pop at full, then at empty
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b1);
    both(8'hAA);
    check("simul_full_count",   32'(bus.rx_count), 8);
    check("simul_full_overrun", 32'(bus.rx_overrun), 0);
    for (int i = 0; i < 8; i++) pop();
    check("simul_full_drained", 32'(bus.rx_count), 0);
    both(8'hBB);
    check("simul_empty_count", 32'(bus.rx_count), 1);
    check("simul_empty_rdata", 32'(bus.apb_rdata), 32'hBB);
    pop();

`ifdef UART_RX_IRQ_EN
    check("irq_idle", 32'(bus.rx_irq), 0);
    push(8'h61, 1'b1);
    check("irq_one", 32'(bus.rx_irq), 0);
    push(8'h62, 1'b1);
    check("irq_two", 32'(bus.rx_irq), 1);
    pop();
    check("irq_pop", 32'(bus.rx_irq), 0);
    pop();
`endif

    // Interleaved traffic across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      push(8'h30 + 8'(i), 1'b1);
      if (i % 2 == 1) begin
        pop();
        pop();
      end
    end
    check("wrap_empty", 32'(bus.rx_count), 0);
    check("wrap_queue", exp_q.size(), 0);

    // Reset mid-operation with recv_done held across release
    for (int i = 0; i < 3; i++) push(8'h70 + 8'(i), 1'b1);
    check("pre_rst_count", 32'(bus.rx_count), 3);
    bus.recv_done = 1'b1;
    bus.recv_data = 8'h99;
    sys_rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    sys_rst = 1'b0;
    repeat (5) tick();
    check("rst_mid_count", 32'(bus.rx_count), 0);
    check("rst_mid_valid", 32'(bus.rx_valid), 0);
    check("rst_mid_rdata", 32'(bus.apb_rdata), 32'h00);
    bus.recv_done = 1'b0;
    tick();
    tick();
    check("rst_mid_nopush", 32'(bus.rx_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
